exec_unit_4: RTL and testbench

//   Multicycle execute stage that drives the 4x4-bit two-read/one-write register file.

---
 rtl/exec_pkg.sv | 25 ++
 rtl/alu_4.sv | 42 ++++
 rtl/exec_unit_4.sv | 107 ++++++++++
 tb/tb_exec_unit_4.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types and widths for the multicycle execute stage
package exec_pkg;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MOV = 3'd5,
    OP_LDI = 3'd6,
    OP_NOP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_4.sv
// rtl/alu_4.sv - combinational 4-bit ALU with carry/borrow and zero detect
module alu_4
  import exec_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  op_e               op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      // The extra bit of the widened difference is the unsigned borrow (a < b).
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = a;
      OP_LDI: result = imm;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/exec_unit_4.sv
// rtl/exec_unit_4.sv - IDLE/READ/EXEC/WRITE execute stage driving a 2R1W register file
module exec_unit_4
  import exec_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [ADDR_W-1:0] i_rs0,
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [DATA_W-1:0] i_imm,
  output logic [ADDR_W-1:0] o_reg_read_0,
  output logic [ADDR_W-1:0] o_reg_read_1,
  input  logic [DATA_W-1:0] i_port_read_0,
  input  logic [DATA_W-1:0] i_port_read_1,
  output logic [ADDR_W-1:0] o_reg_write,
  output logic [DATA_W-1:0] o_port_write,
  output logic              o_write_enable,
  output logic              o_done,
  output logic              o_zero,
  output logic              o_carry
);

  state_e            state, state_n;
  op_e               op_q;
  logic [ADDR_W-1:0] rd_q, rs0_q, rs1_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q, result_q;
  logic              zero_q, carry_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry, alu_zero;

  alu_4 u_alu (
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .op     (op_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (i_valid) state_n = ST_READ;
      ST_READ:  state_n = ST_EXEC;
      ST_EXEC:  state_n = ST_WRITE;
      ST_WRITE: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q     <= OP_ADD;
      rd_q     <= '0;
      rs0_q    <= '0;
      rs1_q    <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (i_valid) begin
          op_q  <= op_e'(i_op);
          rd_q  <= i_rd;
          rs0_q <= i_rs0;
          rs1_q <= i_rs1;
          imm_q <= i_imm;
        end
        ST_READ: begin
          a_q <= i_port_read_0;
          b_q <= i_port_read_1;
        end
        // NOP keeps the previous result so the flags describe the last real op.
        ST_EXEC: if (op_q != OP_NOP) begin
          result_q <= alu_result;
          zero_q   <= alu_zero;
          carry_q  <= alu_carry;
        end
        default: ;
      endcase
    end
  end

  // Write strobe decodes straight from state so an async reset drops it at once.
  assign o_ready        = (state == ST_IDLE);
  assign o_done         = (state == ST_WRITE);
  assign o_write_enable = (state == ST_WRITE) && (op_q != OP_NOP);
  assign o_reg_read_0   = rs0_q;
  assign o_reg_read_1   = rs1_q;
  assign o_reg_write    = rd_q;
  assign o_port_write   = result_q;
  assign o_zero         = zero_q;
  assign o_carry        = carry_q;

endmodule

// File: tb/tb_exec_unit_4.sv
// tb/tb_exec_unit_4.sv - scoreboard bench for exec_unit_4 with a behavioural register file
module tb_exec_unit_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic       ready;
  logic [2:0] op;
  logic [1:0] rd, rs0, rs1;
  logic [3:0] imm;
  logic [1:0] reg_read_0, reg_read_1, reg_write;
  logic [3:0] port_read_0, port_read_1, port_write;
  logic       write_enable, done, zero, carry;

  logic [3:0] rf [4];
  logic       rf_clr;
  int         cyc = 0;
  int         passed = 0;
  int         total = 0;

  typedef struct {
    logic [1:0] rd;
    logic [3:0] data;
    logic       we;
    logic       z;
    logic       c;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  exec_unit_4 dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid        (valid),
    .o_ready        (ready),
    .i_op           (op),
    .i_rd           (rd),
    .i_rs0          (rs0),
    .i_rs1          (rs1),
    .i_imm          (imm),
    .o_reg_read_0   (reg_read_0),
    .o_reg_read_1   (reg_read_1),
    .i_port_read_0  (port_read_0),
    .i_port_read_1  (port_read_1),
    .o_reg_write    (reg_write),
    .o_port_write   (port_write),
    .o_write_enable (write_enable),
    .o_done         (done),
    .o_zero         (zero),
    .o_carry        (carry)
  );

  assign port_read_0 = rf[reg_read_0];
  assign port_read_1 = rf[reg_read_1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_clr) begin
      for (int i = 0; i < 4; i++) rf[i] <= 4'd0;
    end else if (write_enable) begin
      rf[reg_write] <= port_write;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every retired instruction is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("write_enable", int'(write_enable), int'(e.we));
        if (e.we) begin
          chk("write_addr", int'(reg_write), int'(e.rd));
          chk("write_data", int'(port_write), int'(e.data));
        end
        chk("zero_flag", int'(zero), int'(e.z));
        chk("carry_flag", int'(carry), int'(e.c));
        chk("done_latency", cyc, e.done_cyc);
      end
    end
  end

  task automatic send(input logic [2:0] t_op, input logic [1:0] t_rd, input logic [1:0] t_rs0,
                      input logic [1:0] t_rs1, input logic [3:0] t_imm, input logic [3:0] e_data,
                      input logic e_we, input logic e_z, input logic e_c, input bit push,
                      output int waits);
    exp_t e;
    @(negedge clk);
    op = t_op; rd = t_rd; rs0 = t_rs0; rs1 = t_rs1; imm = t_imm; valid = 1'b1;
    waits = 0;
    while (!ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      @(posedge clk);
      #1;
      if (push) begin
        e.rd = t_rd; e.data = e_data; e.we = e_we; e.z = e_z; e.c = e_c;
        e.done_cyc = cyc + 2;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain();
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int w;
    rst_n = 1'b0; rf_clr = 1'b1; valid = 1'b0;
    op = 3'd0; rd = 2'd0; rs0 = 2'd0; rs1 = 2'd0; imm = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_we", int'(write_enable), 0);
    chk("rst_flags", int'({zero, carry}), 0);
    chk("rst_wr_addr_data", int'({reg_write, port_write}), 0);
    chk("rst_rd_addrs", int'({reg_read_0, reg_read_1}), 0);
    rst_n = 1'b1; rf_clr = 1'b0;

    // LDI r1,#5 ; LDI r2,#3
    send(3'd6, 2'd1, 2'd0, 2'd0, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, w); drain();
    send(3'd6, 2'd2, 2'd0, 2'd0, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, w); drain();
    chk("rf_r1_ldi", int'(rf[1]), 5);
    chk("rf_r2_ldi", int'(rf[2]), 3);

    // ADD r3,r1,r2 ; LDI r0,#15 ; ADD r0,r0,r1 (carry out)
    send(3'd0, 2'd3, 2'd1, 2'd2, 4'd0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, w); drain();
    chk("rf_r3_add", int'(rf[3]), 8);
    send(3'd6, 2'd0, 2'd0, 2'd0, 4'd15, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1, w); drain();
    send(3'd0, 2'd0, 2'd0, 2'd1, 4'd0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1, w); drain();
    chk("rf_r0_add_carry", int'(rf[0]), 4);

    // SUB r0,r2,r1 (borrow) ; SUB r0,r1,r1 (zero)
    send(3'd1, 2'd0, 2'd2, 2'd1, 4'd0, 4'd14, 1'b1, 1'b0, 1'b1, 1'b1, w); drain();
    chk("rf_r0_sub_borrow", int'(rf[0]), 14);
    send(3'd1, 2'd0, 2'd1, 2'd1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, w); drain();
    chk("rf_r0_sub_zero", int'(rf[0]), 0);

    // Back-to-back XOR r1,r1,r2 then MOV r3,r1 with i_valid held high
    send(3'd4, 2'd1, 2'd1, 2'd2, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, w);
    send(3'd5, 2'd3, 2'd1, 2'd0, 4'd0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, w);
    chk("busy_cycles", w, 3);
    drain();
    chk("rf_r1_xor", int'(rf[1]), 6);
    chk("rf_r3_mov", int'(rf[3]), 6);

    // Zero result, then NOP keeps flags and writes nothing
    send(3'd1, 2'd0, 2'd1, 2'd1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, w); drain();
    send(3'd7, 2'd2, 2'd0, 2'd0, 4'd9, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, w); drain();
    chk("rf_r2_after_nop", int'(rf[2]), 3);

    // Reset during EXEC of LDI r2,#9 discards the instruction
    send(3'd6, 2'd2, 2'd0, 2'd0, 4'd9, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, w);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    chk("pre_rst_busy", int'({ready, done}), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", int'(ready), 1);
    chk("midrst_we", int'(write_enable), 0);
    chk("midrst_flags", int'({zero, carry}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rf_r2_after_rst", int'(rf[2]), 3);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
